// File: rtl/vx_data_port_arb.sv
// Per-bank data-store port arbiter: fill / core-write / core-read onto one single-port line RAM,
// read data returned through a 2-entry response buffer. Optional perf counters: DATA_ARB_PERF_EN.
module vx_data_port_arb #(
  parameter int CACHE_LINE_SIZE = 16,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int TAG_WIDTH       = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         fill_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]   fill_addr,
  input  logic [8*CACHE_LINE_SIZE-1:0] fill_data,
  output logic                         fill_ready,

  input  logic                         cwr_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]   cwr_addr,
  input  logic [CACHE_LINE_SIZE-1:0]   cwr_byteen,
  input  logic [8*CACHE_LINE_SIZE-1:0] cwr_data,
  output logic                         cwr_ready,

  input  logic                         crd_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]   crd_addr,
  input  logic [TAG_WIDTH-1:0]         crd_tag,
  output logic                         crd_ready,

  output logic [LINE_ADDR_WIDTH-1:0]   ram_addr,
  output logic                         ram_readen,
  output logic                         ram_writeen,
  output logic                         ram_is_fill,
  output logic [CACHE_LINE_SIZE-1:0]   ram_byteen,
  output logic [8*CACHE_LINE_SIZE-1:0] ram_wdata,
  input  logic [8*CACHE_LINE_SIZE-1:0] ram_rdata,

  output logic                         rsp_valid,
  output logic [8*CACHE_LINE_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]         rsp_tag,
  input  logic                         rsp_ready
`ifdef DATA_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_fill_cycles,
  output logic [31:0]                  perf_core_stall_cycles,
  output logic [31:0]                  perf_rsp_stall_cycles
`endif
);

  localparam int LW = 8*CACHE_LINE_SIZE;
  localparam int TW = TAG_WIDTH;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  // arbitration state
  logic [3:0]    starve_cnt;
  logic          rr_is_wr;
  // read pipe and response buffer
  logic          rd_vld_q;
  logic [TW-1:0] rd_tag_q;
  rsp_t          buf_q [2];
  logic          head_q;
  logic [1:0]    cnt_q;

  logic core_valid, starve_hit, rd_ok, pick_rd, pick_wr;
  logic gnt_fill, gnt_cwr, gnt_crd;
  logic bypass, push, pop;
  rsp_t head_ent;

  // Read grants reserve a buffer slot up front, so the buffer can never overflow.
  always_comb begin
    core_valid = cwr_valid | crd_valid;
    starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
    rd_ok      = crd_valid && (({1'b0, cnt_q} + {2'b00, rd_vld_q}) < 3'd2);
    pick_rd    = rd_ok && (!cwr_valid || !rr_is_wr);
    pick_wr    = cwr_valid && !pick_rd;
    gnt_fill   = 1'b0;
    gnt_cwr    = 1'b0;
    gnt_crd    = 1'b0;
    if (reset) begin
      if (fill_valid && !starve_hit) gnt_fill = 1'b1;
      else if (pick_rd)              gnt_crd  = 1'b1;
      else if (pick_wr)              gnt_cwr  = 1'b1;
      else if (fill_valid)           gnt_fill = 1'b1;
    end
  end

  assign fill_ready  = gnt_fill;
  assign cwr_ready   = gnt_cwr;
  assign crd_ready   = gnt_crd;

  assign ram_readen  = gnt_crd;
  assign ram_writeen = gnt_fill | gnt_cwr;
  assign ram_is_fill = gnt_fill;
  assign ram_addr    = gnt_fill ? fill_addr : (gnt_cwr ? cwr_addr : crd_addr);
  assign ram_byteen  = gnt_fill ? {CACHE_LINE_SIZE{1'b1}} : cwr_byteen;
  assign ram_wdata   = gnt_fill ? fill_data : cwr_data;

  // Empty buffer: present the RAM read directly so a read costs one cycle.
  always_comb begin
    head_ent  = buf_q[head_q];
    bypass    = (cnt_q == 2'd0);
    rsp_valid = reset && (bypass ? rd_vld_q : 1'b1);
    rsp_data  = bypass ? ram_rdata : head_ent.data;
    rsp_tag   = bypass ? rd_tag_q  : head_ent.tag;
    push      = rd_vld_q && !(bypass && rsp_ready);
    pop       = !bypass && rsp_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      rr_is_wr   <= 1'b0;
      rd_vld_q   <= 1'b0;
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (gnt_cwr || gnt_crd || !core_valid)
        starve_cnt <= 4'd0;
      else if (gnt_fill && !starve_hit)
        starve_cnt <= starve_cnt + 4'd1;

      if (gnt_crd)      rr_is_wr <= 1'b1;
      else if (gnt_cwr) rr_is_wr <= 1'b0;

      rd_vld_q <= gnt_crd;
      if (pop) head_q <= ~head_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (gnt_crd) rd_tag_q <= crd_tag;
    if (push)    buf_q[head_q ^ cnt_q[0]] <= '{data: ram_rdata, tag: rd_tag_q};
  end

`ifdef DATA_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fill_cycles       <= 32'd0;
      perf_core_stall_cycles <= 32'd0;
      perf_rsp_stall_cycles  <= 32'd0;
    end else begin
      if (gnt_fill)                             perf_fill_cycles       <= perf_fill_cycles + 32'd1;
      if (core_valid && !(gnt_cwr || gnt_crd))  perf_core_stall_cycles <= perf_core_stall_cycles + 32'd1;
      if (rsp_valid && !rsp_ready)              perf_rsp_stall_cycles  <= perf_rsp_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_data_port_arb.sv
// Directed bench for vx_data_port_arb with a behavioural line-RAM model behind the port.
module tb_vx_data_port_arb;
  localparam int LS = 16;
  localparam int LW = 128;
  localparam int AW = 26;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fill_valid, cwr_valid, crd_valid, rsp_ready;
  logic [AW-1:0] fill_addr, cwr_addr, crd_addr, ram_addr;
  logic [LW-1:0] fill_data, cwr_data, ram_wdata, ram_rdata, rsp_data;
  logic [LS-1:0] cwr_byteen, ram_byteen;
  logic [TW-1:0] crd_tag, rsp_tag;
  logic          fill_ready, cwr_ready, crd_ready;
  logic          ram_readen, ram_writeen, ram_is_fill, rsp_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_data_port_arb dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .fill_ready(fill_ready),
    .cwr_valid(cwr_valid), .cwr_addr(cwr_addr), .cwr_byteen(cwr_byteen), .cwr_data(cwr_data),
    .cwr_ready(cwr_ready),
    .crd_valid(crd_valid), .crd_addr(crd_addr), .crd_tag(crd_tag), .crd_ready(crd_ready),
    .ram_addr(ram_addr), .ram_readen(ram_readen), .ram_writeen(ram_writeen), .ram_is_fill(ram_is_fill),
    .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
  );

  // Data store: byte-masked write, registered read; fills write the whole line.
  logic [LW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_writeen)
      for (int b = 0; b < LS; b++)
        if (ram_is_fill || ram_byteen[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    if (ram_readen) ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    fill_valid = 1'b0; cwr_valid = 1'b0; crd_valid = 1'b0;
  endtask

  // Hold fill and core-write valid; pat[i] = 1 means cycle i must grant cwr, else fill.
  task automatic run_fc(input int n, input logic [15:0] pat, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fill_valid = 1'b1; fill_addr = 26'h20;
      cwr_valid  = 1'b1; cwr_addr  = 26'h21; cwr_byteen = 16'h0001;
      crd_valid  = 1'b0;
      #1;
      chk({tag, "_cwr"},  cwr_ready,  pat[i]);
      chk({tag, "_fill"}, fill_ready, !pat[i]);
    end
  endtask

  logic [LW-1:0] p1, p2;
  logic [5:0]    alt;

  initial begin
    p1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    p2 = 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE00;
    reset = 1'b0; rsp_ready = 1'b0;
    fill_addr = '0; fill_data = '0; cwr_addr = '0; cwr_data = '0; cwr_byteen = '0;
    crd_addr = '0; crd_tag = '0;
    fill_valid = 1'b1; cwr_valid = 1'b1; crd_valid = 1'b1;

    // reset: requests present but nothing granted
    @(negedge clk); #1;
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_cwr_ready",  cwr_ready,  1'b0);
    chk("rst_crd_ready",  crd_ready,  1'b0);
    chk("rst_ram_en",     {ram_readen, ram_writeen, ram_is_fill}, 3'b000);
    chk("rst_rsp_valid",  rsp_valid,  1'b0);
    @(negedge clk); reset = 1'b1; drive_idle();

    // fill 0x10 with p1
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = 26'h10; fill_data = p1; cwr_byteen = 16'h0000; #1;
    chk("fill_ready",   fill_ready, 1'b1);
    chk("fill_strobes", {ram_writeen, ram_is_fill, ram_readen}, 3'b110);
    chk("fill_byteen",  ram_byteen, 16'hFFFF);
    chk("fill_addr",    ram_addr,   26'h10);
    chk("fill_wdata",   ram_wdata,  p1);
    // byte-masked core write
    @(negedge clk);
    fill_valid = 1'b0;
    cwr_valid = 1'b1; cwr_addr = 26'h10; cwr_byteen = 16'h000F; cwr_data = {16{8'hAA}}; #1;
    chk("cwr_ready",   cwr_ready,  1'b1);
    chk("cwr_strobes", {ram_writeen, ram_is_fill, ram_readen}, 3'b100);
    chk("cwr_byteen",  ram_byteen, 16'h000F);
    // read back next cycle
    @(negedge clk);
    cwr_valid = 1'b0;
    crd_valid = 1'b1; crd_addr = 26'h10; crd_tag = 8'h03; rsp_ready = 1'b1; #1;
    chk("rd_ready",     crd_ready,  1'b1);
    chk("rd_strobes",   {ram_readen, ram_writeen}, 2'b10);
    chk("rd_addr",      ram_addr,   26'h10);
    chk("rd_rsp_early", rsp_valid,  1'b0);
    @(negedge clk);
    crd_valid = 1'b0; #1;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_tag",   rsp_tag,   8'h03);
    chk("rd_rsp_data",  rsp_data,  128'h00112233_44556677_8899AABB_AAAAAAAA);
    @(negedge clk); #1;
    chk("rd_rsp_gone",  rsp_valid, 1'b0);

    // full fill then read: every byte replaced
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = 26'h11; fill_data = p2; #1;
    chk("fill2_ready", fill_ready, 1'b1);
    @(negedge clk);
    fill_valid = 1'b0; crd_valid = 1'b1; crd_addr = 26'h11; crd_tag = 8'h04; #1;
    chk("rd2_ready", crd_ready, 1'b1);
    @(negedge clk);
    crd_valid = 1'b0; #1;
    chk("rd2_tag",  rsp_tag,  8'h04);
    chk("rd2_data", rsp_data, p2);

    // starvation: F F F F W repeating
    run_fc(10, 16'b0000_0010_0001_0000, "starve");
    @(negedge clk); drive_idle();

    // core read/write round robin, read first
    alt = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      crd_valid = 1'b1; crd_addr = 26'h10; crd_tag = 8'(i);
      cwr_valid = 1'b1; cwr_addr = 26'h30; cwr_byteen = 16'h0001; #1;
      chk("rr_crd", crd_ready, alt[i]);
      chk("rr_cwr", cwr_ready, !alt[i]);
    end
    @(negedge clk); drive_idle(); rsp_ready = 1'b0;

    // backpressure: buffer holds two, third read blocked
    @(negedge clk); crd_valid = 1'b1; crd_tag = 8'h0A; #1;
    chk("bp_rd0", crd_ready, 1'b1);
    @(negedge clk); crd_tag = 8'h0B; #1;
    chk("bp_rd1", crd_ready, 1'b1);
    chk("bp_rsp_a_v", rsp_valid, 1'b1);
    chk("bp_rsp_a_t", rsp_tag, 8'h0A);
    @(negedge clk); crd_tag = 8'h0C; #1;
    chk("bp_rd2_blk", crd_ready, 1'b0);
    chk("bp_hold_t",  rsp_tag, 8'h0A);
    @(negedge clk); #1;
    chk("bp_rd3_blk", crd_ready, 1'b0);
    chk("bp_hold_v",  rsp_valid, 1'b1);
    @(negedge clk); crd_valid = 1'b0; rsp_ready = 1'b1; #1;
    chk("bp_pop_a", rsp_tag, 8'h0A);
    @(negedge clk); #1;
    chk("bp_pop_b_v", rsp_valid, 1'b1);
    chk("bp_pop_b_t", rsp_tag, 8'h0B);
    @(negedge clk); #1;
    chk("bp_empty", rsp_valid, 1'b0);

    // reset with a read in flight and one response buffered
    rsp_ready = 1'b0;
    @(negedge clk); crd_valid = 1'b1; crd_tag = 8'h01; #1;
    chk("r6_rd1", crd_ready, 1'b1);
    @(negedge clk); crd_tag = 8'h02; #1;
    chk("r6_rd2", crd_ready, 1'b1);
    @(negedge clk); reset = 1'b0; fill_valid = 1'b1; cwr_valid = 1'b1; #1;
    chk("r6_rsp_valid", rsp_valid, 1'b0);
    chk("r6_readies", {fill_ready, cwr_ready, crd_ready}, 3'b000);
    @(negedge clk); reset = 1'b1; fill_valid = 1'b0; crd_tag = 8'h07; #1;
    chk("r6_drop", rsp_valid, 1'b0);
    chk("r6_rr_crd", crd_ready, 1'b1);
    chk("r6_rr_cwr", cwr_ready, 1'b0);
    @(negedge clk); drive_idle(); rsp_ready = 1'b1; #1;
    chk("r6_new_v", rsp_valid, 1'b1);
    chk("r6_new_t", rsp_tag, 8'h07);

    // reset clears a partially built starvation count
    run_fc(2, 16'b0000, "pre");
    @(negedge clk); reset = 1'b0; #1;
    chk("r6b_readies", {fill_ready, cwr_ready}, 2'b00);
    @(negedge clk); reset = 1'b1; fill_valid = 1'b1; cwr_valid = 1'b1; #1;
    chk("r6b_c0_fill", fill_ready, 1'b1);
    run_fc(4, 16'b1000, "post");
    @(negedge clk); drive_idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
